// File: rtl/apu_uart_tx_if.sv
// apu_uart_tx_if: register-write request handshake (address, data, valid/ready) into apu_uart_tx.
interface apu_uart_tx_if;
  logic [3:0] tx_addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_addr, tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_addr, tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/apu_uart_tx.sv
// apu_uart_tx: serialises (addr, data) register writes as two 8N1 characters on tx.
// Define APU_UART_TX_PARITY_EN to add an even-parity bit to each character.
module apu_uart_tx #(
  parameter int OVERSAMPLE = 5,
  parameter int GAP_BITS   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         uart_clk,
  apu_uart_tx_if.slave bus,
  output logic         tx,
  output logic         busy
);
  localparam int SW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  localparam int GW = GAP_BITS > 1 ? $clog2(GAP_BITS) : 1;
  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
`ifdef APU_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    GAP
  } state_t;
  state_t        state;
  logic [SW-1:0] sub;
  logic [GW-1:0] gap;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    data_q;
  logic          second;
  logic          ready;
`ifdef APU_UART_TX_PARITY_EN
  logic          par;
`endif
  logic          wrap;
  assign wrap = uart_clk && sub == SW'(OVERSAMPLE - 1);
  assign bus.tx_ready = ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sub    <= '0;
      gap    <= '0;
      idx    <= '0;
      shreg  <= '0;
      data_q <= '0;
      second <= 1'b0;
      ready  <= 1'b1;
      tx     <= 1'b1;
      busy   <= 1'b0;
`ifdef APU_UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      // bit-period sub-counter only runs while a bit is on the line
      if (uart_clk && state != IDLE && state != ALIGN) sub <= wrap ? '0 : sub + 1'b1;
      case (state)
        IDLE: if (bus.tx_valid) begin
          shreg  <= {4'b1000, bus.tx_addr};
          data_q <= bus.tx_data;
          second <= 1'b0;
          ready  <= 1'b0;
          busy   <= 1'b1;
          state  <= ALIGN;
        end
        ALIGN: if (uart_clk) begin
          tx    <= 1'b0;
          state <= START;
        end
        START: if (wrap) begin
          tx    <= shreg[0];
          shreg <= shreg >> 1;
          idx   <= '0;
`ifdef APU_UART_TX_PARITY_EN
          par   <= shreg[0];
`endif
          state <= DATA;
        end
        DATA: if (wrap) begin
          if (idx == 3'd7) begin
`ifdef APU_UART_TX_PARITY_EN
            tx    <= par;
            state <= PARITY;
`else
            tx    <= 1'b1;
            state <= STOP;
`endif
          end else begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            idx   <= idx + 1'b1;
`ifdef APU_UART_TX_PARITY_EN
            par   <= par ^ shreg[0];
`endif
          end
        end
`ifdef APU_UART_TX_PARITY_EN
        PARITY: if (wrap) begin
          tx    <= 1'b1;
          state <= STOP;
        end
`endif
        // character 1 starts straight after character 0's stop bit
        STOP: if (wrap) begin
          if (!second) begin
            shreg  <= data_q;
            second <= 1'b1;
            tx     <= 1'b0;
            state  <= START;
          end else begin
            gap   <= '0;
            state <= GAP;
          end
        end
        GAP: if (wrap) begin
          if (gap == GW'(GAP_BITS - 1)) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apu_uart_tx.sv
// tb_apu_uart_tx: random register writes scored against a bit-list model of the serial frame.
module tb_apu_uart_tx;
  localparam int OS = 5;
  localparam int GB = 2;
`ifdef APU_UART_TX_PARITY_EN
  localparam int CB = 11;
`else
  localparam int CB = 10;
`endif
  localparam int NB    = 2 * CB;
  localparam int FRAME = (NB + GB) * OS;
  logic clk = 0;
  logic rst = 1;
  logic uart_clk = 0;
  logic tx, busy;
  apu_uart_tx_if bus();
  apu_uart_tx #(.OVERSAMPLE(OS), .GAP_BITS(GB)) dut (
    .clk(clk), .rst(rst), .uart_clk(uart_clk), .bus(bus), .tx(tx), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int uperiod = 37, ucnt = 0, pulses = 0;
  int pushed = 0, frames_done = 0, aborted = 0, rb_err = 0;
  logic [NB-1:0] expq[$];
  logic [NB-1:0] cur;
  bit in_frame = 0, have_prev = 0, bits_ok;
  int p0 = 0, prev_p0 = 0;
  always @(posedge clk) if (uart_clk) pulses <= pulses + 1;
  initial forever begin
    @(negedge clk);
    ucnt++;
    uart_clk = (uperiod == 0) ? 1'b0 : (ucnt % uperiod == 0);
  end
  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask
  // expected line bits in transmission order: start, data LSB first, [parity], stop
  function automatic logic [NB-1:0] build(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] ch [2];
    bit q[$];
    ch[0] = {4'h8, a};
    ch[1] = d;
    for (int c = 0; c < 2; c++) begin
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(ch[c][i]);
`ifdef APU_UART_TX_PARITY_EN
      q.push_back(^ch[c]);
`endif
      q.push_back(1'b1);
    end
    build = '0;
    foreach (q[i]) build[i] = q[i];
  endfunction
  initial forever begin
    int k;
    @(negedge clk);
    if (rst) begin
      if (in_frame) aborted++;
      in_frame = 0;
      have_prev = 0;
      continue;
    end
    if (bus.tx_ready !== !busy) rb_err++;
    if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1;
        p0 = pulses;
        bits_ok = 1;
        if (have_prev) chk("start_separation", (p0 - prev_p0 >= FRAME + 1) ? 1 : 0, 1);
        prev_p0 = p0;
        have_prev = 1;
        if (expq.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          cur = '1;
        end else cur = expq.pop_front();
      end
    end
    if (in_frame) begin
      k = pulses - p0;
      if (k < NB * OS) begin
        if (tx !== cur[k / OS] || busy !== 1'b1) bits_ok = 0;
      end else if (k < FRAME) begin
        if (tx !== 1'b1 || busy !== 1'b1) bits_ok = 0;
      end else begin
        chk("frame_bits", bits_ok, 1);
        chk("busy_drop_at_frame_end", busy, 0);
        frames_done++;
        in_frame = 0;
      end
    end
  end
  task automatic send(input logic [3:0] a, input logic [7:0] d, input bit hold);
    int n = 0;
    @(negedge clk);
    bus.tx_addr = a;
    bus.tx_data = d;
    bus.tx_valid = 1;
    while (!bus.tx_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", (n < 6000) ? 1 : 0, 1);
    expq.push_back(build(a, d));
    pushed++;
    if (!hold) begin
      @(negedge clk);
      bus.tx_valid = 0;
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || in_frame || busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", (n < 6000) ? 1 : 0, 1);
  endtask
  initial begin
    int low, n;
    int periods[5] = '{1, 2, 3, 5, 7};
    bus.tx_addr = '0;
    bus.tx_data = '0;
    bus.tx_valid = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", bus.tx_ready, 1);
    send(4'h3, 8'hA5, 0);
    wait_idle();
    uperiod = 5;
    send(4'h8, 8'hFF, 0);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      uperiod = periods[$urandom_range(0, 4)];
      send(4'($urandom), 8'($urandom), 0);
      wait_idle();
    end
    uperiod = 3;
    send(4'h1, 8'h00, 1);
    send(4'hE, 8'h5A, 1);
    send(4'hF, 8'hC3, 0);
    wait_idle();
    uperiod = 2;
    send(4'h6, 8'h81, 0);
    repeat (40) @(negedge clk);
    chk("busy_before_pulse", busy, 1);
    bus.tx_addr = 4'h9;
    bus.tx_data = 8'h77;
    bus.tx_valid = 1;
    @(negedge clk);
    bus.tx_valid = 0;
    wait_idle();
    uperiod = 0;
    send(4'hC, 8'h12, 0);
    repeat (200) @(negedge clk);
    chk("stall_tx", tx, 1);
    chk("stall_busy", busy, 1);
    chk("stall_ready", bus.tx_ready, 0);
    uperiod = 5;
    wait_idle();
    uperiod = 2;
    send(4'h5, 8'h3C, 0);
    n = 0;
    while (!(in_frame && pulses - p0 >= 27) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mid_char", (n < 6000) ? 1 : 0, 1);
    rst = 1;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_reset_tx", tx, 1);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_ready", bus.tx_ready, 1);
    low = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    chk("quiet_after_reset", low, 0);
    chk("frames_accounted", frames_done + aborted, pushed);
    chk("queue_drained", expq.size(), 0);
    chk("ready_eq_not_busy", rb_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
